// File: rtl/cnn_pkg.sv
// Shared types and lane arithmetic for the PE-mesh output path.
package cnn_pkg;

   typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

   localparam int unsigned LaneW = 16;
   localparam logic [LaneW-1:0] LaneMax = {1'b0, {(LaneW-1){1'b1}}};
   localparam logic [LaneW-1:0] LaneMin = {1'b1, {(LaneW-1){1'b0}}};

   // Returns {overflow, clamped sum} for one signed lane.
   function automatic logic [LaneW:0] sat_add(input logic [LaneW-1:0] a,
                                              input logic [LaneW-1:0] b);
      logic [LaneW:0] s;
      logic           ovf;
      s   = {a[LaneW-1], a} + {b[LaneW-1], b};
      ovf = s[LaneW] ^ s[LaneW-1];
      if (!ovf) return {1'b0, s[LaneW-1:0]};
      return {1'b1, s[LaneW] ? LaneMin : LaneMax};
   endfunction

endpackage

// File: rtl/psum_fifo.sv
// Show-ahead FIFO holding completed result vectors; head reads 0 when empty.
module psum_fifo #(
   parameter int unsigned DW  = 64,
   parameter int unsigned LOG = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic [LOG:0]  count,
   output logic          full,
   output logic          empty
);

   localparam int unsigned Depth = 1 << LOG;

   logic [DW-1:0]  mem_q [Depth];
   logic [LOG-1:0] wr_ptr_q, rd_ptr_q;
   logic [LOG:0]   count_q;
   logic           do_push, do_pop;

   assign full    = (count_q == (LOG+1)'(Depth));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{LOG{1'b0}}, do_push} - {{LOG{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/psum_collector.sv
// Accumulates per-row partial sums over N passes and queues result vectors.
// Define PSUM_SATURATE_EN for clamping lane adds with a sticky overflow flag.
module psum_collector
   import cnn_pkg::*;
#(
   parameter int unsigned depth    = 2,
   parameter int unsigned D        = 1 << depth,
   parameter int unsigned W        = LaneW,
   parameter int unsigned PASS_W   = 8,
   parameter int unsigned VEC_W    = 12,
   parameter int unsigned FIFO_LOG = 2
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              start,
   input  logic [PASS_W-1:0] numPasses,
   input  logic [VEC_W-1:0]  numVectors,
   input  logic [W*D-1:0]    psIn,
   input  logic              psValid,
   output logic              psReady,
   output logic [W*D-1:0]    outData,
   output logic              outValid,
   input  logic              outReady,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   state_e            state_q;
   logic [PASS_W-1:0] pass_last_q, pass_cnt_q;
   logic [VEC_W-1:0]  vec_last_q, vec_cnt_q;
   logic [W-1:0]      acc_q [D];
   logic [W*D-1:0]    sum;
   logic              done_q;
   logic              accept, last_pass, last_vec, push, pop;
   logic [FIFO_LOG:0] fifo_count;
   logic              fifo_full, fifo_empty;

   assign psReady   = (state_q == StAccum) && !fifo_full;
   assign accept    = psValid && psReady;
   assign last_pass = (pass_cnt_q == pass_last_q);
   assign last_vec  = (vec_cnt_q == vec_last_q);
   assign push      = accept && last_pass;
   assign outValid  = !fifo_empty;
   assign pop       = outValid && outReady;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;

`ifdef PSUM_SATURATE_EN
   logic [D-1:0] lane_ovf;
   logic         ovf_q;
   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

   for (genvar i = 0; i < D; i++) begin : g_lane
      logic [W-1:0] in_lane;
      assign in_lane = psIn[W*(i+1)-1 -: W];
`ifdef PSUM_SATURATE_EN
      logic [W:0] res;
      assign res                  = sat_add(acc_q[i], in_lane);
      assign sum[W*(i+1)-1 -: W] = res[W-1:0];
      assign lane_ovf[i]          = res[W];
`else
      assign sum[W*(i+1)-1 -: W] = acc_q[i] + in_lane;
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q     <= StIdle;
         pass_last_q <= '0;
         pass_cnt_q  <= '0;
         vec_last_q  <= '0;
         vec_cnt_q   <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < D; i++) acc_q[i] <= '0;
`ifdef PSUM_SATURATE_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  // Zero counts behave as one.
                  pass_last_q <= (numPasses == '0) ? '0 : numPasses - PASS_W'(1);
                  vec_last_q  <= (numVectors == '0) ? '0 : numVectors - VEC_W'(1);
                  pass_cnt_q  <= '0;
                  vec_cnt_q   <= '0;
                  for (int i = 0; i < D; i++) acc_q[i] <= '0;
`ifdef PSUM_SATURATE_EN
                  ovf_q <= 1'b0;
`endif
                  state_q <= StAccum;
               end
            end
            StAccum: begin
               if (accept) begin
                  if (last_pass) begin
                     // The final sum goes straight into the FIFO, not through acc.
                     for (int i = 0; i < D; i++) acc_q[i] <= '0;
                     pass_cnt_q <= '0;
                     vec_cnt_q  <= vec_cnt_q + VEC_W'(1);
                     if (last_vec) state_q <= StDrain;
                  end else begin
                     for (int i = 0; i < D; i++) acc_q[i] <= sum[W*i +: W];
                     pass_cnt_q <= pass_cnt_q + PASS_W'(1);
                  end
`ifdef PSUM_SATURATE_EN
                  ovf_q <= ovf_q | (|lane_ovf);
`endif
               end
            end
            StDrain: begin
               if (fifo_empty || (fifo_count == (FIFO_LOG+1)'(1) && pop)) begin
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   psum_fifo #(
      .DW  (W*D),
      .LOG (FIFO_LOG)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RSTn),
      .push      (push),
      .push_data (sum),
      .pop       (pop),
      .head      (outData),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: doc/psum_collector.md
# psum_collector

Output-side companion of the convolutional PE mesh. Accepts the D per-row partial sums the mesh emits each pass, accumulates them over a programmed number of passes (input-channel/kernel tiles), and queues each completed D-wide result vector in a small show-ahead FIFO toward the output neuron buffer over a valid/ready handshake. A job produces a programmed number of result vectors, then returns to idle.

## Interface
- depth, 2, log2 of mesh dimension
- D, 1<<depth, rows (lanes) per vector
- W, 16, lane width, signed two's complement
- PASS_W, 8, width of pass-count configuration
- VEC_W, 12, width of vector-count configuration
- FIFO_LOG, 2, log2 of output FIFO depth (4 entries)

- CLK  in  1  clock, all logic on rising edge
- RSTn  in  1  synchronous active-low reset
- start  in  1  one-cycle job start; latches numPasses, numVectors
- numPasses  in  PASS_W  passes per result vector; 0 treated as 1
- numVectors  in  VEC_W  result vectors per job; 0 treated as 1
- psIn  in  W*D  row partial sums from mesh, lane i at [W*(i+1)-1 -:W]
- psValid  in  1  psIn valid
- psReady  out  1  collector accepts psIn this cycle
- outData  out  W*D  FIFO head vector
- outValid  out  1  FIFO non-empty
- outReady  in  1  downstream consumes head
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, job complete
- overflow  out  1  sticky saturation flag (see Configuration)

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE: start=1 -> latch counts, clear accumulators, passCnt=0, vecCnt=0, overflow=0 -> ACCUM. start in other states ignored.
- ACCUM: psReady = !fifoFull. Beat accepted on psValid&&psReady.
  - Non-last pass: acc[i] <= acc[i] + psIn lane i; passCnt++.
  - Last pass (passCnt==numPasses-1): push acc[i]+psIn lane i into FIFO (bypasses acc register), acc<=0, passCnt<=0, vecCnt++.
  - Last pass of last vector -> DRAIN.
- DRAIN: psReady=0; when FIFO empty -> done pulse, -> IDLE.
- Arithmetic: per-lane signed W-bit add, no cross-lane carry.
- FIFO: push and pop in the same cycle allowed at any occupancy except full (no push when full since psReady=0); pop when full frees a slot, psReady rises next cycle.
- outData holds stable while outValid && !outReady.
- Reset (any state, mid-job): acc=0, counters=0, FIFO emptied, state IDLE; in-flight data discarded.

## Timing
- Reset values: psReady=0, outData=0, outValid=0, busy=0, done=0, overflow=0.
- Last-pass beat accepted at edge t -> outValid=1 after edge t (visible cycle t+1) when FIFO was empty.
- Full throughput: one beat per cycle while outReady=1 continuously.
- psReady registered-free: combinational from state and FIFO count only (no dependence on psValid).
- done asserted exactly one cycle, cycle after final pop empties FIFO (or cycle after entering DRAIN if already empty).

## Configuration
- PSUM_SATURATE_EN defined: each lane add clamps to +2^(W-1)-1 / -2^(W-1) on signed overflow; overflow sets and holds until next start or reset.
- Undefined: wrap-around modulo 2^W; overflow tied 0.

## Structure
- Shared package cnn_pkg: state encoding (IDLE/ACCUM/DRAIN), lane-slice width constants, saturating-add helper function.
- One sub-module: psum_fifo (parameterised W*D wide, 2^FIFO_LOG deep, show-ahead, count output).

## Test plan
- Reset mid-job: D=4, numPasses=3, drop RSTn after 2 beats -> all outputs reset values, next job starts clean.
- Basic accumulate: numPasses=3, numVectors=1, lanes {1,2,3,4} x3 beats -> outData {3,6,9,12}, outValid next cycle after 3rd beat, done after pop.
- numPasses=0, numVectors=0 -> treated as 1/1: single beat {5,-5,7,0} emitted unchanged.
- Backpressure: numPasses=1, numVectors=6, outReady=0 -> 4 vectors queued, psReady=0; raise outReady -> remaining 2 accepted in order, data intact.
- Overflow: lane0 beats 0x7000+0x7000; with PSUM_SATURATE_EN -> 0x7FFF, overflow=1; without -> 0xE000, overflow=0.
- start while busy ignored; simultaneous push/pop at 3 entries keeps count 3.
